// File: rtl/product_accumulator_if.sv
// product_accumulator_if: input/output handshake bundle for product_accumulator.
// Ports (slave side = accumulator):
//   in_valid/in_ready/products  : input handshake carrying N packed signed products
//   out_valid/out_ready         : output handshake
//   sum/sum_sat/sat             : full-precision sum, clamped sum, clamp flag
//   busy                        : accumulator is not idle
interface product_accumulator_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 3
);
  localparam int N         = KERNEL_SIZE * KERNEL_SIZE;
  localparam int ACC_WIDTH = DATA_WIDTH + $clog2(N);
  logic                    in_valid;
  logic                    in_ready;
  logic [N*DATA_WIDTH-1:0] products;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_WIDTH-1:0]    sum;
  logic [DATA_WIDTH-1:0]   sum_sat;
  logic                    sat;
  logic                    busy;
  modport slave (
    input  in_valid, products, out_ready,
    output in_ready, out_valid, sum, sum_sat, sat, busy
  );
  modport master (
    output in_valid, products, out_ready,
    input  in_ready, out_valid, sum, sum_sat, sat, busy
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sequentially sums a captured vector of N signed products with saturation.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : product_accumulator_if.slave (input/output handshakes, sum, sum_sat, sat, busy)
// One element is added per cycle, so a result appears N edges after the accept edge.
module product_accumulator #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  product_accumulator_if.slave bus
);
  localparam int N         = KERNEL_SIZE * KERNEL_SIZE;
  localparam int SEL_WIDTH = $clog2(N);
  localparam int ACC_WIDTH = DATA_WIDTH + SEL_WIDTH;
  localparam int IDX_WIDTH = SEL_WIDTH + 1;
  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;
  state_t                  state, state_n;
  logic [N*DATA_WIDTH-1:0] vec;
  logic [DATA_WIDTH-1:0]   elems [N];
  logic [DATA_WIDTH-1:0]   elem;
  logic [ACC_WIDTH-1:0]    acc, acc_n, sum_q;
  logic [IDX_WIDTH-1:0]    idx;
  logic [ACC_WIDTH-DATA_WIDTH:0] hi;
  logic [DATA_WIDTH-1:0]   sum_sat_n, sum_sat_q;
  logic                    last, ovf, sat_q;
  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign elems[g] = vec[g*DATA_WIDTH +: DATA_WIDTH];
  end
  always_comb begin
    elem      = elems[idx[SEL_WIDTH-1:0]];
    acc_n     = acc + {{(ACC_WIDTH-DATA_WIDTH){elem[DATA_WIDTH-1]}}, elem};
    last      = idx == IDX_WIDTH'(N-1);
    // the sum fits DATA_WIDTH only if all bits from DATA_WIDTH-1 upward agree
    hi        = acc_n[ACC_WIDTH-1:DATA_WIDTH-1];
    ovf       = (|hi) & ~(&hi);
    sum_sat_n = ovf ? {acc_n[ACC_WIDTH-1], {(DATA_WIDTH-1){~acc_n[ACC_WIDTH-1]}}}
                    : acc_n[DATA_WIDTH-1:0];
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.in_valid ? ACCUM : IDLE;
      ACCUM:   state_n = last ? OUTPUT : ACCUM;
      OUTPUT:  state_n = bus.out_ready ? IDLE : OUTPUT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= '0;
      acc       <= '0;
      idx       <= '0;
      sum_q     <= '0;
      sum_sat_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.in_valid) begin
        vec <= bus.products;
        acc <= '0;
        idx <= '0;
      end else if (state == ACCUM) begin
        acc <= acc_n;
        // idx parks on the last element so it never points past N-1
        idx <= last ? idx : idx + 1'b1;
        if (last) begin
          sum_q     <= acc_n;
          sum_sat_q <= sum_sat_n;
          sat_q     <= ovf;
        end
      end
    end
  end
  assign bus.in_ready  = state == IDLE;
  assign bus.busy      = state != IDLE;
  assign bus.out_valid = state == OUTPUT;
  assign bus.sum       = sum_q;
  assign bus.sum_sat   = sum_sat_q;
  assign bus.sat       = sat_q;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: randomized and directed scoreboard bench for product_accumulator.
module tb_product_accumulator;
  localparam int DW = 32;
  localparam int KS = 3;
  localparam int N  = KS * KS;
  localparam int AW = 36;
  typedef struct {longint s; logic [DW-1:0] ss; logic st;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  exp_t exp_q[$];
  exp_t e;
  logic [AW-1:0] p_sum;
  logic [DW-1:0] p_ss;
  logic          p_sat;
  bit            held = 0;
  always #5 clk = ~clk;
  product_accumulator_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS)) bus ();
  product_accumulator #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic chk(input string name, input longint got, input longint want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, want);
  endtask
  function automatic exp_t model(input logic [N*DW-1:0] v);
    exp_t r;
    longint s = 0;
    for (int i = 0; i < N; i++) s += longint'($signed(v[i*DW +: DW]));
    r.s  = s;
    r.st = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    r.ss = (s > 64'sd2147483647) ? 32'h7fffffff : (s < -64'sd2147483648) ? 32'h80000000 : s[31:0];
    return r;
  endfunction
  function automatic logic [N*DW-1:0] vec_all(input logic [DW-1:0] x);
    return {N{x}};
  endfunction
  function automatic logic [N*DW-1:0] vec_idx(input bit neg);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = neg ? DW'(-i) : DW'(i);
    return v;
  endfunction
  function automatic logic [N*DW-1:0] rand_vec(input int mode);
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++)
      v[i*DW +: DW] = (mode == 0) ? DW'($urandom)
                    : (mode == 1) ? DW'($urandom_range(0, 200)) - 32'd100
                    : $urandom_range(0, 1) ? 32'h7fffffff - DW'($urandom_range(0, 3))
                                           : 32'h80000000 + DW'($urandom_range(0, 3));
    return v;
  endfunction
  // scoreboard monitor: compares on every output handshake, checks hold while stalled
  always @(negedge clk) begin
    if (!rst_n) held = 0;
    else if (bus.out_valid) begin
      if (held) begin
        chk("hold_sum", longint'(bus.sum), longint'(p_sum));
        chk("hold_sum_sat", longint'(bus.sum_sat), longint'(p_ss));
        chk("hold_sat", longint'(bus.sat), longint'(p_sat));
      end
      if (bus.out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("sum", longint'($signed(bus.sum)), e.s);
          chk("sum_sat", longint'(bus.sum_sat), longint'(e.ss));
          chk("sat", longint'(bus.sat), longint'(e.st));
        end
        held = 0;
      end else begin
        held  = 1;
        p_sum = bus.sum;
        p_ss  = bus.sum_sat;
        p_sat = bus.sat;
      end
    end else held = 0;
  end
  task automatic send(input logic [N*DW-1:0] v);
    int n = 0;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.products = v;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.products = rand_vec(0);
    exp_q.push_back(model(v));
  endtask
  task automatic wait_out();
    int n = 0;
    while (!bus.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", n, N);
  endtask
  task automatic drain();
    int n = 0;
    bus.out_ready = 1'b1;
    while (bus.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("drain_out_valid", longint'(bus.out_valid), 0);
  endtask
  initial begin
    bus.in_valid  = 1'b0;
    bus.products  = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", longint'(bus.in_ready), 1);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_sum", longint'(bus.sum), 0);
    chk("rst_sum_sat", longint'(bus.sum_sat), 0);
    chk("rst_sat", longint'(bus.sat), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(vec_all(32'd1));        wait_out(); drain();
    send(vec_idx(0));            wait_out(); drain();
    send(vec_idx(1));            wait_out(); drain();
    send(vec_all(32'h7fffffff)); wait_out(); drain();
    send(vec_all(32'h80000000)); wait_out(); drain();
    bus.out_ready = 1'b0;
    send(vec_all(32'd5));
    wait_out();
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.products = rand_vec(0);
      @(posedge clk); #1;
      chk("stall_in_ready", longint'(bus.in_ready), 0);
      chk("stall_out_valid", longint'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_out_valid", longint'(bus.out_valid), 0);
    chk("hs_no_accept", longint'(bus.busy), 0);
    bus.in_valid = 1'b0;
    send(vec_all(32'd3)); wait_out(); drain();
    send(vec_all(32'd7));
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", longint'(bus.out_valid), 0);
    chk("abort_in_ready", longint'(bus.in_ready), 1);
    chk("abort_busy", longint'(bus.busy), 0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1 chk("abort_no_result", longint'(bus.out_valid), 0);
    send(vec_all(32'd2)); wait_out(); drain();
    for (int k = 0; k < 30; k++) begin
      bus.out_ready = 1'b0;
      send(rand_vec(k % 3));
      wait_out();
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      chk("rand_out_valid", longint'(bus.out_valid), 1);
      drain();
    end
    repeat (2) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
